// File: rtl/mux_n_to_1_stream_pkg.sv
// Shared definitions for the N-to-1 stream multiplexer: channel-choice modes
// and the constant clog2 used to size the channel-index ports.
package mux_n_to_1_stream_pkg;

  typedef enum logic {
    MODE_FIXED = 1'b0,
    MODE_RR    = 1'b1
  } mode_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      r = ((32'sd1 <<< i) < value) ? (i + 1) : r;
    end
    return r;
  endfunction

endpackage

// File: rtl/mux_n_to_1_stream_if.sv
// Handshake bundle between the producers, the multiplexer and the consumer.
interface mux_n_to_1_stream_if
  import mux_n_to_1_stream_pkg::*;
#(
  parameter int b = 8,
  parameter int N = 4
);
  localparam int SW = clog2(N);

  logic [N*b-1:0] in_data;
  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_ready;
  logic           mode;
  logic [SW-1:0]  sel;
  logic [b-1:0]   out_data;
  logic [SW-1:0]  out_chan;
  logic           out_valid;
  logic           out_ready;

  modport master (
    output in_data, in_valid, mode, sel, out_ready,
    input  in_ready, out_data, out_chan, out_valid
  );

  modport slave (
    input  in_data, in_valid, mode, sel, out_ready,
    output in_ready, out_data, out_chan, out_valid
  );

endinterface

// File: rtl/mux_n_to_1_stream_rr_picker.sv
// Round-robin picker: first requesting channel at or after ptr, wrapping mod N.
// Rotates the request vector so ptr sits at bit 0, then priority-scans.
module mux_n_to_1_stream_rr_picker
  import mux_n_to_1_stream_pkg::*;
#(
  parameter int N  = 4,
  parameter int SW = clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [SW-1:0] ptr_i,
  output logic [SW-1:0] g_o,
  output logic          gv_o
);

  logic [N-1:0]  rot_s;
  logic [SW-1:0] off_s;
  logic [SW:0]   sum_s;

  // Rotated priority scan; the offset is added back to ptr with an explicit wrap at N
  always_comb begin
    rot_s = N'({req_i, req_i} >> ptr_i);
    off_s = '0;
    for (int i = N - 1; i >= 0; i--) begin
      off_s = rot_s[i] ? SW'(i) : off_s;
    end
    sum_s = {1'b0, ptr_i} + {1'b0, off_s};
    g_o   = (sum_s >= (SW+1)'(N)) ? SW'(sum_s - (SW+1)'(N)) : sum_s[SW-1:0];
    gv_o  = |req_i;
  end

endmodule

// File: rtl/mux_n_to_1_stream.sv
// Registered N-channel stream multiplexer with valid/ready on every input and
// on the output; channel chosen by sel (FIXED) or by round-robin rotation (RR).
module mux_n_to_1_stream
  import mux_n_to_1_stream_pkg::*;
#(
  parameter int b = 8,
  parameter int N = 4
) (
  input logic               clk,
  input logic               reset,
  mux_n_to_1_stream_if.slave bus
);

  localparam int SW = clog2(N);

  logic [b-1:0]  out_data_q, out_data_d;
  logic [SW-1:0] out_chan_q, out_chan_d;
  logic          out_valid_q, out_valid_d;
  logic [SW-1:0] rr_ptr_q, rr_ptr_d;

  logic [SW-1:0] rr_g_s, g_s;
  logic          rr_gv_s, gv_s, slot_free_s;
  logic [b-1:0]  sel_data_s;
  logic [N-1:0]  in_ready_s;

  mux_n_to_1_stream_rr_picker #(
    .N  (N),
    .SW (SW)
  ) u_rr_picker (
    .req_i (bus.in_valid),
    .ptr_i (rr_ptr_q),
    .g_o   (rr_g_s),
    .gv_o  (rr_gv_s)
  );

  // Grant selection, data mux and per-channel ready decode
  always_comb begin
    g_s         = bus.sel;
    gv_s        = 1'b0;
    sel_data_s  = '0;
    in_ready_s  = '0;
    slot_free_s = ~out_valid_q | bus.out_ready;
    if (bus.mode == MODE_RR) begin
      g_s  = rr_g_s;
      gv_s = rr_gv_s;
    end else begin
      // An out-of-range sel matches no channel, so nothing is granted
      for (int i = 0; i < N; i++) begin
        gv_s = (bus.sel == SW'(i)) ? bus.in_valid[i] : gv_s;
      end
    end
    for (int i = 0; i < N; i++) begin
      sel_data_s    = (g_s == SW'(i)) ? bus.in_data[i*b +: b] : sel_data_s;
      in_ready_s[i] = gv_s & slot_free_s & (g_s == SW'(i)) & ~reset;
    end
  end

  // Next-state for the output slot and the round-robin pointer
  always_comb begin
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    out_valid_d = out_valid_q;
    rr_ptr_d    = rr_ptr_q;
    if (slot_free_s) begin
      if (gv_s) begin
        out_data_d  = sel_data_s;
        out_chan_d  = g_s;
        out_valid_d = 1'b1;
        rr_ptr_d    = (g_s == SW'(N - 1)) ? '0 : g_s + SW'(1);
      end else begin
        out_valid_d = 1'b0;
      end
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // Output word, channel tag and pointer registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_data_q  <= '0;
      out_chan_q  <= '0;
      out_valid_q <= 1'b0;
      rr_ptr_q    <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
      out_valid_q <= out_valid_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_data  = out_data_q;
  assign bus.out_chan  = out_chan_q;
  assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_mux_n_to_1_stream.sv
// Directed bench for mux_n_to_1_stream: an N=4 instance for the main scenarios
// and an N=3 instance for out-of-range sel and the non-power-of-two wrap.
module tb_mux_n_to_1_stream;
  import mux_n_to_1_stream_pkg::*;

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  mux_n_to_1_stream_if #(.b(8), .N(4)) bus4 ();
  mux_n_to_1_stream_if #(.b(8), .N(3)) bus3 ();

  mux_n_to_1_stream #(.b(8), .N(4)) u_dut4 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus4)
  );

  mux_n_to_1_stream #(.b(8), .N(3)) u_dut3 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] onehot;
    int         c;
    errors = 0;
    checks = 0;
    reset  = 1'b0;
    bus4.in_data   = {8'h04, 8'h03, 8'h02, 8'h01};
    bus4.in_valid  = 4'hF;
    bus4.mode      = MODE_RR;
    bus4.sel       = 2'd0;
    bus4.out_ready = 1'b1;
    bus3.in_data   = {8'h33, 8'h22, 8'h11};
    bus3.in_valid  = 3'b000;
    bus3.mode      = MODE_FIXED;
    bus3.sel       = 2'd0;
    bus3.out_ready = 1'b1;

    // Reset state, with requests pending so in_ready gating is visible
    #1 reset = 1'b1;
    #1;
    chk("rst_out_valid", 32'(bus4.out_valid), 32'd0);
    chk("rst_out_data",  32'(bus4.out_data),  32'h00);
    chk("rst_out_chan",  32'(bus4.out_chan),  32'd0);
    chk("rst_in_ready",  32'(bus4.in_ready),  32'h0);
    tick();
    reset = 1'b0;

    // 1: FIXED mode walks sel 0..3
    bus4.mode = MODE_FIXED;
    for (int s = 0; s < 4; s++) begin
      bus4.sel = 2'(s);
      onehot = 4'b0001 << s;
      #1;
      chk("fixed_in_ready", 32'(bus4.in_ready), 32'(onehot));
      tick();
      chk("fixed_out_data",  32'(bus4.out_data),  32'(s + 1));
      chk("fixed_out_chan",  32'(bus4.out_chan),  32'(s));
      chk("fixed_out_valid", 32'(bus4.out_valid), 32'd1);
    end

    // 2: RR with all channels valid; pointer is 0 after the sel=3 grant
    bus4.mode = MODE_RR;
    for (int i = 0; i < 8; i++) begin
      c = i % 4;
      onehot = 4'b0001 << c;
      #1;
      chk("rr_all_in_ready", 32'(bus4.in_ready), 32'(onehot));
      tick();
      chk("rr_all_out_chan", 32'(bus4.out_chan), 32'(c));
      chk("rr_all_out_data", 32'(bus4.out_data), 32'(c + 1));
    end

    // 3: RR with only channels 1 and 3 requesting
    bus4.in_valid = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      c = (i % 2 == 0) ? 1 : 3;
      onehot = 4'b0001 << c;
      #1;
      chk("rr_sparse_in_ready", 32'(bus4.in_ready), 32'(onehot));
      tick();
      chk("rr_sparse_out_chan", 32'(bus4.out_chan), 32'(c));
    end

    // 4: backpressure holds channel 3 / 0x04 for three cycles
    bus4.in_valid  = 4'hF;
    bus4.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_in_ready", 32'(bus4.in_ready), 32'h0);
      tick();
      chk("stall_out_chan",  32'(bus4.out_chan),  32'd3);
      chk("stall_out_data",  32'(bus4.out_data),  32'h04);
      chk("stall_out_valid", 32'(bus4.out_valid), 32'd1);
    end
    bus4.out_ready = 1'b1;
    #1;
    chk("release_in_ready", 32'(bus4.in_ready), 32'h1);
    tick();
    chk("release_out_chan", 32'(bus4.out_chan), 32'd0);
    chk("release_out_data", 32'(bus4.out_data), 32'h01);
    bus4.in_valid = 4'h0;
    tick();
    chk("drain_out_valid", 32'(bus4.out_valid), 32'd0);
    chk("drain_out_data",  32'(bus4.out_data),  32'h01);

    // 5: N=3, sel=2 then out-of-range sel=3, then RR wrap 2->0
    bus3.in_valid = 3'b111;
    bus3.sel      = 2'd2;
    #1;
    chk("n3_sel2_in_ready", 32'(bus3.in_ready), 32'h4);
    tick();
    chk("n3_sel2_out_data", 32'(bus3.out_data), 32'h33);
    chk("n3_sel2_out_chan", 32'(bus3.out_chan), 32'd2);
    bus3.sel = 2'd3;
    #1;
    chk("n3_sel3_in_ready", 32'(bus3.in_ready), 32'h0);
    tick();
    chk("n3_sel3_out_valid", 32'(bus3.out_valid), 32'd0);
    chk("n3_sel3_out_data",  32'(bus3.out_data),  32'h33);
    bus3.mode = MODE_RR;
    for (int i = 0; i < 4; i++) begin
      c = i % 3;
      #1;
      chk("n3_rr_in_ready", 32'(bus3.in_ready), 32'(3'b001 << c));
      tick();
      chk("n3_rr_out_chan", 32'(bus3.out_chan), 32'(c));
      chk("n3_rr_out_data", 32'(bus3.out_data), 32'(8'h11 * (c + 1)));
    end

    // 6: reset while a word is held; pointer was 1 after the channel-0 grant
    bus4.in_valid = 4'hF;
    tick();
    chk("pre_rst_out_chan",  32'(bus4.out_chan),  32'd1);
    chk("pre_rst_out_valid", 32'(bus4.out_valid), 32'd1);
    bus4.out_ready = 1'b0;
    reset = 1'b1;
    #1;
    chk("async_rst_out_valid", 32'(bus4.out_valid), 32'd0);
    chk("async_rst_out_data",  32'(bus4.out_data),  32'h00);
    chk("async_rst_in_ready",  32'(bus4.in_ready),  32'h0);
    tick();
    reset = 1'b0;
    bus4.out_ready = 1'b1;
    #1;
    chk("post_rst_in_ready", 32'(bus4.in_ready), 32'h1);
    tick();
    chk("post_rst_out_chan", 32'(bus4.out_chan), 32'd0);
    chk("post_rst_out_data", 32'(bus4.out_data), 32'h01);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
